// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: controller states and
// the add/subtract mode encoding.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder: parity sum and true majority carry. This is the only
// arithmetic in the serial adder/subtractor.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor. It processes one bit per cycle, LSB
// first, through a single full-adder cell and keeps the carry in a flip-flop.
module serial_addsub
  import arith_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_c;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  fa_cell u_fa (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_c)
  );

  // A new request is accepted in IDLE and also in DONE, which gives
  // back-to-back operation with no idle gap.
  assign w_load     = start && (r_state != RUN);
  assign w_last     = (r_cnt == LAST_BIT);
  assign w_res_next = {w_s, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      // Subtraction is a + ~b + 1: invert B here and seed the carry with 1.
      r_a     <= a;
      r_b     <= (sub == MODE_SUB) ? ~b : b;
      r_carry <= (sub == MODE_SUB);
      r_cnt   <= '0;
      r_res   <= '0;
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          r_res   <= w_res_next;
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            // r_carry is the carry into the MSB on this final bit.
            r_sum   <= w_res_next;
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random bench for serial_addsub: expected results are queued
// when an operation is issued and compared when done pulses.
module tb_serial_addsub;
  import arith_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic v);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = v;
    return e;
  endfunction

  // Reference: whole-word addition of a and the (possibly inverted) b.
  function automatic exp_t model(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   t;
    exp_t             e;
    yy     = s ? ~y : y;
    t      = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, s};
    e.sum  = t[WIDTH-1:0];
    e.cout = t[WIDTH];
    e.ovf  = (x[WIDTH-1] == yy[WIDTH-1]) && (e.sum[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_op(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input exp_t e);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    q.push_back(e);
    step();
    start = 1'b0;
  endtask

  // edges counts clock edges starting from the edge that sampled start (=1).
  task automatic wait_done(input string tag, input int cnt0, output int edges, output int busy_cyc);
    exp_t e;
    edges    = cnt0;
    busy_cyc = 0;
    while (!done && edges < 4 * WIDTH + 8) begin
      if (busy) busy_cyc++;
      step();
      edges++;
    end
    chk({tag, ".done_seen"}, done, 1);
    chk({tag, ".sb_size"}, q.size(), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".sum"}, sum, e.sum);
      chk({tag, ".cout"}, cout, e.cout);
      chk({tag, ".ovf"}, ovf, e.ovf);
    end
  endtask

  initial begin
    int edges;
    int bc;
    int seen;
    logic             rs;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] ry;

    @(negedge clk);
    step();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.sum", sum, 0);
    chk("rst.cout", cout, 0);
    chk("rst.ovf", ovf, 0);
    rst_n = 1'b1;
    step();

    start_op(MODE_ADD, 8'h0F, 8'h01, mk(8'h10, 1'b0, 1'b0));
    wait_done("add0F01", 1, edges, bc);
    chk("add0F01.edges", edges, WIDTH + 1);
    chk("add0F01.busy_cycles", bc, WIDTH);
    chk("add0F01.busy_in_done", busy, 0);
    step();
    chk("add0F01.done_one_cycle", done, 0);
    step();
    chk("idle.sum_held", sum, 8'h10);

    start_op(MODE_ADD, 8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b0));
    wait_done("addFF01", 1, edges, bc);
    start_op(MODE_ADD, 8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b1));
    wait_done("add7F01", 1, edges, bc);
    start_op(MODE_SUB, 8'h05, 8'h07, mk(8'hFE, 1'b0, 1'b0));
    wait_done("sub0507", 1, edges, bc);
    start_op(MODE_SUB, 8'h80, 8'h01, mk(8'h7F, 1'b1, 1'b1));
    wait_done("sub8001", 1, edges, bc);
    step();

    // start pulsed mid-run with different operands must be ignored
    start_op(MODE_ADD, 8'h21, 8'h13, mk(8'h34, 1'b0, 1'b0));
    step();
    step();
    start = 1'b1;
    sub   = MODE_SUB;
    a     = 8'hEE;
    b     = 8'h11;
    step();
    start = 1'b0;
    chk("ignore.sum_held_during_run", sum, 8'h7F);
    chk("ignore.busy", busy, 1);
    wait_done("ignore", 4, edges, bc);
    chk("ignore.edges", edges, WIDTH + 1);

    // back-to-back: new start issued in the DONE cycle
    start_op(MODE_SUB, 8'h30, 8'h10, mk(8'h20, 1'b1, 1'b0));
    chk("b2b.no_idle_gap", busy, 1);
    chk("b2b.sum_held", sum, 8'h34);
    chk("b2b.done_low", done, 0);
    wait_done("b2b", 1, edges, bc);
    chk("b2b.edges", edges, WIDTH + 1);
    step();

    // asynchronous reset in the 4th RUN cycle
    start_op(MODE_ADD, 8'h12, 8'h34, mk(8'h46, 1'b0, 1'b0));
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.sum", sum, 0);
    chk("midrst.cout", cout, 0);
    chk("midrst.ovf", ovf, 0);
    q.delete();
    seen = 0;
    @(negedge clk);
    step();
    if (done) seen++;
    rst_n = 1'b1;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      step();
      if (done || busy) seen++;
    end
    chk("midrst.no_done_or_busy", seen, 0);

    start_op(MODE_ADD, 8'h55, 8'hAA, mk(8'hFF, 1'b0, 1'b0));
    wait_done("postrst", 1, edges, bc);
    chk("postrst.edges", edges, WIDTH + 1);

    for (int n = 0; n < 1000; n++) begin
      rs = 1'($urandom_range(0, 1));
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      start_op(rs, rx, ry, model(rs, rx, ry));
      wait_done("rand", 1, edges, bc);
      chk("rand.edges", edges, WIDTH + 1);
      if (n % 3 == 0) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor for WIDTH-bit operands.
- Reuses a single 1-bit full-adder cell over WIDTH cycles, LSB first, with a saved carry flip-flop between cycles.
- Sits beside the combinational arithmetic cells as the low-area option when latency is acceptable.
- Adds a subtract mode, carry/borrow and signed-overflow flags, and a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is 2 or more.
- CW, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only when busy=0.
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result, held until the next accepted start.
- cout  out  1  carry out of the MSB; for subtract, 1 means no borrow (a >= b unsigned).
- ovf  out  1  two's-complement overflow.

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces all of the following to 0: state=IDLE, busy, done, sum, cout, ovf, counter, carry register and operand shift registers.
- State IDLE, start=1:
  - Load shift register A <= a.
  - Load shift register B <= (sub ? ~b : b).
  - Load carry <= sub.
  - Load counter <= 0.
  - Clear the result shift register.
  - Go to RUN.
- State IDLE, start=0: remain in IDLE.
- State RUN, each cycle:
  - Cell computes s = A[0]^B[0]^carry and c = majority(A[0], B[0], carry).
  - s is shifted into the result register from the MSB side.
  - A and B shift right by one bit; carry <= c; counter increments.
  - On the cycle where counter == WIDTH-1:
    - Capture ovf = carry_in_to_MSB ^ c.
    - Capture cout = c.
    - Transfer the full result to sum.
    - Go to DONE.
- State DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next state is IDLE, or RUN directly if start=1 in this cycle (back-to-back accepted, same load rules).
- busy=1 exactly while state=RUN.
- Latency:
  - start sampled at edge k.
  - busy high for cycles k+1 to k+WIDTH.
  - done high in the cycle after edge k+WIDTH+... i.e. the single DONE cycle; WIDTH+1 edges from start to done.
  - Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored; latched operands are unaffected.
- sum, cout and ovf update only when leaving RUN. They are stable in all other cycles, including during a following operation until it completes.
- Width rules:
  - Modular WIDTH-bit result.
  - Subtract computes a + ~b + 1.
  - No sign extension; the flags carry the out-of-range information.
- Reset mid-operation: the operation is abandoned immediately, outputs return to 0, and no done pulse is issued.
- The carry cell must use the true majority function; an OR of the operands is not acceptable.

Decomposition:
- Shared package arith_pkg holds:
  - state enum: IDLE, RUN, DONE
  - localparam MODE_ADD = 1'b0
  - localparam MODE_SUB = 1'b1
- Sub-module fa_cell holds the combinational 1-bit sum/majority-carry cell.
  - Ports: x, y, ci, s, co.
  - Instantiated once; it is the only arithmetic logic in the block.

Test Plan (WIDTH=8):
- add 0x0F+0x01 -> sum=0x10, cout=0, ovf=0; done exactly 9 edges after start; busy high for 8 cycles.
- add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0; add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
- sub 0x05-0x07 -> sum=0xFE, cout=0, ovf=0; sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- start pulsed with new operands mid-RUN -> ignored; result matches the first operands. Then start asserted in the DONE cycle -> new op runs back-to-back with no IDLE gap.
- rst_n low at RUN cycle 4 -> all outputs 0 asynchronously, no done pulse. First op after release, 0x55+0xAA -> sum=0xFF, cout=0, ovf=0.
- Random 1000 ops, both modes, compared against a reference model; also run WIDTH=2 and WIDTH=16 builds with the same checks.
